// File: rtl/exec_pkg.sv
// rtl/exec_pkg.sv - shared types and ALU/compare evaluation for the execute stage
package exec_pkg;

  typedef enum logic [1:0] {
    IT_REG_REG = 2'b00,
    IT_PC_REG  = 2'b01,
    IT_REG_IMM = 2'b10,
    IT_PC_IMM  = 2'b11
  } e_inst_type;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL,
    ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU, ALU_MUL
  } e_alu_function;

  typedef enum logic [2:0] {
    CMP_EQ, CMP_NE, CMP_LT, CMP_GE, CMP_LTU, CMP_GEU
  } e_cmp_function;

  typedef enum logic [1:0] {
    ST_EMPTY, ST_MUL, ST_FULL
  } e_exec_state;

  localparam int WORD_W = 64;
  typedef logic [WORD_W-1:0] word_t;

  // Operands arrive sign-extended to WORD_W; callers keep the low xlen bits.
  function automatic word_t alu_eval(input e_alu_function fn, input word_t a,
                                     input word_t b, input int xlen);
    word_t mask;
    logic [5:0] sh;
    word_t r;
    mask = (xlen >= WORD_W) ? '1 : ((word_t'(1) << xlen) - word_t'(1));
    sh = b[5:0] & 6'(xlen - 1);
    case (fn)
      ALU_ADD:  r = a + b;
      ALU_SUB:  r = a - b;
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_XOR:  r = a ^ b;
      ALU_SLL:  r = a << sh;
      ALU_SRL:  r = (a & mask) >> sh;
      ALU_SRA:  r = word_t'($signed(a) >>> sh);
      ALU_SLT:  r = word_t'($signed(a) < $signed(b));
      ALU_SLTU: r = word_t'(a < b);
      default:  r = '0;
    endcase
    return r;
  endfunction

  // Sign extension preserves unsigned ordering, so the unsigned compares stay valid.
  function automatic logic cmp_eval(input e_cmp_function fn, input word_t a, input word_t b);
    logic r;
    case (fn)
      CMP_EQ:  r = (a == b);
      CMP_NE:  r = (a != b);
      CMP_LT:  r = ($signed(a) < $signed(b));
      CMP_GE:  r = ($signed(a) >= $signed(b));
      CMP_LTU: r = (a < b);
      CMP_GEU: r = (a >= b);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/execute_pipe_mul_iter.sv
// rtl/execute_pipe_mul_iter.sv - iterative multiplier (module exec_mul_iter), MUL_BITS of b per cycle
module exec_mul_iter
  import exec_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MUL_BITS = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int ITERS = XLEN / MUL_BITS;
  localparam int CW    = (ITERS > 1) ? $clog2(ITERS) : 1;

  logic [XLEN-1:0]     a_q, b_q, acc, prod;
  logic [CW-1:0]       cnt;
  logic                busy;
  logic [MUL_BITS-1:0] slice;
  int                  sh;

  always_comb begin
    sh     = MUL_BITS * int'(cnt);
    slice  = MUL_BITS'(b_q >> sh);
    prod   = a_q * XLEN'(slice);
    result = acc + (prod << sh);
    done   = busy && (cnt == CW'(ITERS - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q  <= '0;
      b_q  <= '0;
      acc  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (abort) begin
      acc  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (start) begin
      a_q  <= a;
      b_q  <= b;
      acc  <= '0;
      cnt  <= '0;
      busy <= 1'b1;
    end else if (busy) begin
      acc <= result;
      cnt <= cnt + CW'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/execute_pipe.sv
// rtl/execute_pipe.sv - handshaked execute stage with bypass, crossbars and iterative multiply
module execute_pipe
  import exec_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MUL_BITS = 8,
  parameter bit FWD_EN   = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_imm,
  input  logic [XLEN-1:0] in_pred_next_pc,
  input  e_inst_type      in_inst_type,
  input  e_alu_function   in_alu_function,
  input  e_cmp_function   in_cmp_function,
  input  logic            in_multicycle,
  input  logic [4:0]      in_rs1,
  input  logic [4:0]      in_rs2,
  input  logic [4:0]      in_rd,
  input  logic            in_is_linking_branch,
  output logic [4:0]      rf_rs1,
  output logic [4:0]      rf_rs2,
  input  logic [XLEN-1:0] rf_rs1_val,
  input  logic [XLEN-1:0] rf_rs2_val,
  input  logic            fwd_valid,
  input  logic [4:0]      fwd_rd,
  input  logic [XLEN-1:0] fwd_val,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_alu,
  output logic [XLEN-1:0] out_pred_next_pc,
  output logic            out_cmp,
  output e_inst_type      out_inst_type,
  output logic [4:0]      out_rd,
  output logic            out_is_linking_branch
);

  e_exec_state     state, state_next;
  logic            accept, mul_done;
  logic [XLEN-1:0] op1, op2, alu_a, alu_b, cmp_a, cmp_b, mul_result;

  function automatic word_t sx(input logic [XLEN-1:0] v);
    return word_t'($signed(v));
  endfunction

  assign rf_rs1 = in_rs1;
  assign rf_rs2 = in_rs2;

  always_comb begin
    op1 = (FWD_EN && fwd_valid && fwd_rd == in_rs1 && in_rs1 != 5'd0) ? fwd_val : rf_rs1_val;
    op2 = (FWD_EN && fwd_valid && fwd_rd == in_rs2 && in_rs2 != 5'd0) ? fwd_val : rf_rs2_val;
    alu_a = in_inst_type[0] ? in_pc  : op1;
    cmp_a = in_inst_type[0] ? op1    : in_pc;
    alu_b = in_inst_type[1] ? in_imm : op2;
    cmp_b = in_inst_type[1] ? op2    : in_imm;
  end

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_EMPTY;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: if (accept) state_next = in_multicycle ? ST_MUL : ST_FULL;
        ST_MUL:   if (mul_done) state_next = ST_FULL;
        ST_FULL:  if (out_ready) state_next = accept ? (in_multicycle ? ST_MUL : ST_FULL) : ST_EMPTY;
        default:  state_next = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    in_ready  = !flush && (state == ST_EMPTY || (state == ST_FULL && out_ready));
    out_valid = !flush && (state == ST_FULL);
  end

  exec_mul_iter #(
    .XLEN     (XLEN),
    .MUL_BITS (MUL_BITS)
  ) u_mul (
    .clk    (clk),
    .rst    (rst),
    .start  (accept && in_multicycle),
    .abort  (flush),
    .a      (alu_a),
    .b      (alu_b),
    .done   (mul_done),
    .result (mul_result)
  );

  // Pass-through fields are latched at accept even for MUL; out_valid hides them until done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_pc                <= '0;
      out_alu               <= '0;
      out_pred_next_pc      <= '0;
      out_cmp               <= 1'b0;
      out_inst_type         <= IT_REG_REG;
      out_rd                <= '0;
      out_is_linking_branch <= 1'b0;
    end else if (!flush) begin
      if (accept) begin
        out_pc                <= in_pc;
        out_pred_next_pc      <= in_pred_next_pc;
        out_inst_type         <= in_inst_type;
        out_rd                <= in_rd;
        out_is_linking_branch <= in_is_linking_branch;
        if (!in_multicycle) begin
          out_alu <= XLEN'(alu_eval(in_alu_function, sx(alu_a), sx(alu_b), XLEN));
          out_cmp <= cmp_eval(in_cmp_function, sx(cmp_a), sx(cmp_b));
        end
      end else if (state == ST_MUL && mul_done) begin
        out_alu <= mul_result;
        out_cmp <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_execute_pipe.sv
// tb/tb_execute_pipe.sv - directed and randomized self-checking bench for execute_pipe
module tb_execute_pipe;
  import exec_pkg::*;

  localparam int ITERS = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, in_multicycle, in_is_linking_branch;
  logic [31:0] in_pc, in_imm, in_pred_next_pc;
  e_inst_type    in_inst_type;
  e_alu_function in_alu_function;
  e_cmp_function in_cmp_function;
  logic [4:0]  in_rs1, in_rs2, in_rd, rf_rs1, rf_rs2, fwd_rd, out_rd;
  logic [31:0] rf_rs1_val, rf_rs2_val, fwd_val;
  logic        fwd_valid, flush, out_valid, out_ready, out_cmp, out_is_linking_branch;
  logic [31:0] out_pc, out_alu, out_pred_next_pc;
  e_inst_type  out_inst_type;

  logic [31:0] regs [32];
  assign rf_rs1_val = regs[rf_rs1];
  assign rf_rs2_val = regs[rf_rs2];

  execute_pipe dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_imm(in_imm), .in_pred_next_pc(in_pred_next_pc),
    .in_inst_type(in_inst_type), .in_alu_function(in_alu_function),
    .in_cmp_function(in_cmp_function), .in_multicycle(in_multicycle),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_is_linking_branch(in_is_linking_branch),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_rs1_val(rf_rs1_val), .rf_rs2_val(rf_rs2_val),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_val(fwd_val),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_alu(out_alu), .out_pred_next_pc(out_pred_next_pc),
    .out_cmp(out_cmp), .out_inst_type(out_inst_type), .out_rd(out_rd),
    .out_is_linking_branch(out_is_linking_branch)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] pc, alu, pnpc;
    logic        cmp;
    e_inst_type  it;
    logic [4:0]  rd;
    logic        link;
  } exp_t;

  function automatic logic [31:0] ref_alu(input e_alu_function f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_XOR:  return a ^ b;
      ALU_SLL:  return a << b[4:0];
      ALU_SRL:  return a >> b[4:0];
      ALU_SRA:  return $signed(a) >>> b[4:0];
      ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
      ALU_MUL:  return a * b;
      default:  return 32'd0;
    endcase
  endfunction

  function automatic logic ref_cmp(input e_cmp_function f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      CMP_EQ:  return a == b;
      CMP_NE:  return a != b;
      CMP_LT:  return $signed(a) < $signed(b);
      CMP_GE:  return $signed(a) >= $signed(b);
      CMP_LTU: return a < b;
      CMP_GEU: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic exp_t predict();
    exp_t e;
    logic [31:0] o1, o2, a, b, ca, cb;
    o1 = (fwd_valid && fwd_rd == in_rs1 && in_rs1 != 0) ? fwd_val : regs[in_rs1];
    o2 = (fwd_valid && fwd_rd == in_rs2 && in_rs2 != 0) ? fwd_val : regs[in_rs2];
    a  = in_inst_type[0] ? in_pc : o1;
    ca = in_inst_type[0] ? o1 : in_pc;
    b  = in_inst_type[1] ? in_imm : o2;
    cb = in_inst_type[1] ? o2 : in_imm;
    e.pc = in_pc; e.pnpc = in_pred_next_pc; e.it = in_inst_type;
    e.rd = in_rd; e.link = in_is_linking_branch;
    e.alu = in_multicycle ? a * b : ref_alu(in_alu_function, a, b);
    e.cmp = in_multicycle ? 1'b0 : ref_cmp(in_cmp_function, ca, cb);
    return e;
  endfunction

  // Reference: one held result plus a countdown for an in-flight multiply.
  exp_t m_exp;
  bit   m_have = 0;
  int   m_pend = 0;

  initial begin
    bit rdy;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_have = 0; m_pend = 0;
      end else begin
        rdy = !flush && m_pend == 0 && (!m_have || out_ready);
        chk("in_ready", 32'(in_ready), 32'(rdy));
        chk("out_valid", 32'(out_valid), 32'(m_have && !flush));
        chk("rf_rs1", 32'(rf_rs1), 32'(in_rs1));
        chk("rf_rs2", 32'(rf_rs2), 32'(in_rs2));
        if (m_have && !flush && out_valid) begin
          chk("out_pc", out_pc, m_exp.pc);
          chk("out_alu", out_alu, m_exp.alu);
          chk("out_cmp", 32'(out_cmp), 32'(m_exp.cmp));
          chk("out_pnpc", out_pred_next_pc, m_exp.pnpc);
          chk("out_inst_type", 32'(out_inst_type), 32'(m_exp.it));
          chk("out_rd", 32'(out_rd), 32'(m_exp.rd));
          chk("out_link", 32'(out_is_linking_branch), 32'(m_exp.link));
        end
      end
      @(posedge clk);
      if (rst || flush) begin
        m_have = 0; m_pend = 0;
      end else if (m_pend > 0) begin
        m_pend--;
        if (m_pend == 0) m_have = 1;
      end else begin
        rdy = in_valid && (!m_have || out_ready);
        if (m_have && out_ready) m_have = 0;
        if (rdy) begin
          m_exp = predict();
          if (in_multicycle) m_pend = ITERS;
          else m_have = 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input e_alu_function f, input e_inst_type it, input logic [4:0] r1,
                        input logic [4:0] r2, input logic [31:0] imm);
    in_valid = 1'b1; in_alu_function = f; in_inst_type = it;
    in_rs1 = r1; in_rs2 = r2; in_imm = imm; in_multicycle = (f == ALU_MUL);
    in_cmp_function = CMP_EQ; in_rd = 5'd7; in_pc = 32'h100; in_pred_next_pc = 32'h104;
    in_is_linking_branch = 1'b0;
  endtask

  task automatic run_mul(input string name, input logic [4:0] r1, input logic [4:0] r2,
                         input e_inst_type it, input logic [31:0] imm, input logic [31:0] exp);
    int lat;
    lat = 0;
    tick();
    set_op(ALU_MUL, it, r1, r2, imm);
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= 10 && lat == 0; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) lat = k;
      else chk({name, "_in_ready_busy"}, 32'(in_ready), 32'd0);
    end
    chk({name, "_latency"}, lat, ITERS);
    chk(name, out_alu, exp);
  endtask

  e_alu_function fns [11] = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL,
                              ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU, ALU_MUL};

  initial begin
    in_valid = 0; flush = 0; out_ready = 1; fwd_valid = 0; fwd_rd = 0; fwd_val = 0;
    set_op(ALU_ADD, IT_REG_REG, 0, 0, 0);
    in_valid = 0;
    foreach (regs[i]) regs[i] = $urandom;
    regs[0] = 0; regs[1] = 10; regs[2] = 3; regs[3] = 7; regs[4] = 6; regs[5] = 32'hFFFF_FFFF;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_alu", out_alu, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_rd", 32'(out_rd), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 1);

    // back-to-back ADD then SUB
    tick();
    set_op(ALU_ADD, IT_REG_REG, 1, 2, 0);
    tick();
    set_op(ALU_SUB, IT_REG_REG, 1, 2, 0);
    @(negedge clk);
    chk("add_10_3", out_alu, 13);
    tick();
    in_valid = 0;
    @(negedge clk);
    chk("sub_10_3", out_alu, 7);
    chk("b2b_valid_2nd", 32'(out_valid), 1);
    tick();
    @(negedge clk);
    chk("b2b_drain", 32'(out_valid), 0);

    // forwarding
    tick();
    set_op(ALU_ADD, IT_REG_IMM, 1, 0, 1);
    fwd_valid = 1; fwd_rd = 1; fwd_val = 100;
    tick();
    in_valid = 0; fwd_val = 55;
    @(negedge clk);
    chk("fwd_addi", out_alu, 101);
    tick();
    set_op(ALU_ADD, IT_REG_IMM, 0, 0, 1);
    fwd_rd = 0;
    tick();
    in_valid = 0; fwd_valid = 0;
    @(negedge clk);
    chk("fwd_x0_ignored", out_alu, 1);

    run_mul("mul_7x6", 3, 4, IT_REG_REG, 0, 42);
    run_mul("mul_ffff_x2", 5, 0, IT_REG_IMM, 2, 32'hFFFF_FFFE);

    // backpressure
    tick();
    out_ready = 0;
    set_op(ALU_ADD, IT_REG_REG, 1, 2, 0);
    tick();
    set_op(ALU_SUB, IT_REG_REG, 1, 2, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_hold_alu", out_alu, 13);
      chk("bp_hold_valid", 32'(out_valid), 1);
      chk("bp_in_ready", 32'(in_ready), 0);
      tick();
    end
    out_ready = 1;
    tick();
    in_valid = 0;
    @(negedge clk);
    chk("bp_release_next", out_alu, 7);

    // flush during the second multiply cycle
    tick();
    set_op(ALU_MUL, IT_REG_REG, 3, 4, 0);
    tick();
    in_valid = 0;
    tick();
    flush = 1;
    tick();
    flush = 0;
    @(negedge clk);
    chk("flush_in_ready", 32'(in_ready), 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("flush_no_valid", 32'(out_valid), 0);
    end

    // async reset mid-multiply
    tick();
    set_op(ALU_MUL, IT_REG_REG, 3, 4, 0);
    tick();
    in_valid = 0;
    tick();
    #2;
    rst = 1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 0);
    chk("arst_out_alu", out_alu, 0);
    chk("arst_out_pc", out_pc, 0);
    tick();
    rst = 0;
    tick();
    set_op(ALU_ADD, IT_REG_REG, 1, 2, 0);
    tick();
    in_valid = 0;
    @(negedge clk);
    chk("post_rst_add", out_alu, 13);

    // randomized traffic, checked by the reference process
    for (int c = 0; c < 3000; c++) begin
      tick();
      regs[1 + ($urandom % 31)] = $urandom;
      in_valid = ($urandom % 3) != 0;
      out_ready = ($urandom % 4) != 0;
      flush = ($urandom % 32) == 0;
      in_alu_function = fns[$urandom % 11];
      in_multicycle = (in_alu_function == ALU_MUL);
      in_cmp_function = e_cmp_function'($urandom % 6);
      in_inst_type = e_inst_type'(2'($urandom));
      in_rs1 = 5'($urandom % 8); in_rs2 = 5'($urandom % 8); in_rd = 5'($urandom);
      in_pc = $urandom; in_pred_next_pc = $urandom;
      in_imm = ($urandom % 2) ? $urandom : 32'($urandom % 40);
      in_is_linking_branch = 1'($urandom);
      fwd_valid = 1'($urandom); fwd_rd = 5'($urandom % 8); fwd_val = $urandom;
    end
    tick();
    in_valid = 0; flush = 0; out_ready = 1;
    repeat (10) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
